// File: rtl/dsp48a1_op_sequencer.sv
// Sequencer driving one DSP48A1 slice: accepts a request, holds the operands while the
// fully-registered pipeline fills, fires CEP once, and presents P/CARRYOUT to the consumer.
//
// state | meaning
// IDLE  | waiting for a request or a P clear; operand registers hold last values
// CLR   | one-cycle RSTP pulse to zero the P register before an accumulate chain
// RUN   | slice clock enables high while the pipeline fills; CEP on the final edge
// RESP  | result valid, waiting for the consumer
module dsp48a1_op_sequencer #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [17:0] req_a,
    input  logic [17:0] req_b,
    input  logic [17:0] req_d,
    input  logic [47:0] req_c,
    input  logic        req_carryin,
    input  logic        acc_clr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [47:0] rsp_p,
    output logic        rsp_carryout,
    output logic        busy,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [17:0] dsp_d,
    output logic [47:0] dsp_c,
    output logic        dsp_carryin,
    output logic [7:0]  dsp_opmode,
    output logic        dsp_ce,
    output logic        dsp_cep,
    output logic        dsp_rstp,
    input  logic [47:0] dsp_p,
    input  logic        dsp_carryout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       load;

    // Bit 5 of OPMODE carries the per-request carry-in value.
    function automatic logic [7:0] opmode_of(input logic [1:0] op, input logic cin);
        logic [7:0] m;
        case (op)
            2'd0:    m = 8'b0001_1101;
            2'd1:    m = 8'b1000_1101;
            2'd2:    m = 8'b0000_0001;
            default: m = 8'b0001_1001;
        endcase
        m[5] = cin;
        return m;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            dsp_a       <= '0;
            dsp_b       <= '0;
            dsp_d       <= '0;
            dsp_c       <= '0;
            dsp_carryin <= 1'b0;
            dsp_opmode  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load) begin
                dsp_a       <= req_a;
                dsp_b       <= req_b;
                dsp_d       <= req_d;
                dsp_c       <= req_c;
                dsp_carryin <= req_carryin;
                dsp_opmode  <= opmode_of(req_op, req_carryin);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        req_ready = 1'b0;
        dsp_ce    = 1'b0;
        dsp_cep   = 1'b0;
        dsp_rstp  = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = ~rst & ~acc_clr;
                if (acc_clr) begin
                    state_nxt = CLR;
                end else if (req_valid && req_ready) begin
                    load      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            CLR: begin
                dsp_rstp  = 1'b1;
                state_nxt = IDLE;
            end
            RUN: begin
                dsp_ce = 1'b1;
                // P must capture exactly once so accumulate ops add a single product.
                if (cnt == CNT_LAST) begin
                    dsp_cep   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy         = (state != IDLE);
    assign rsp_p        = rsp_valid ? dsp_p : 48'd0;
    assign rsp_carryout = rsp_valid & dsp_carryout;

endmodule

// File: tb/tb_dsp48a1_op_sequencer.sv
// Bench for dsp48a1_op_sequencer with a behavioural DSP48A1 slice model and a response scoreboard.
module tb_dsp48a1_op_sequencer;

    localparam int LAT = 4;

    logic        clk, rst;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [17:0] req_a, req_b, req_d;
    logic [47:0] req_c;
    logic        req_carryin, acc_clr;
    logic        rsp_valid, rsp_ready;
    logic [47:0] rsp_p;
    logic        rsp_carryout, busy;
    logic [17:0] dsp_a, dsp_b, dsp_d;
    logic [47:0] dsp_c;
    logic        dsp_carryin;
    logic [7:0]  dsp_opmode;
    logic        dsp_ce, dsp_cep, dsp_rstp;
    logic [47:0] dsp_p;
    logic        dsp_carryout;

    dsp48a1_op_sequencer #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_d(req_d), .req_c(req_c),
        .req_carryin(req_carryin), .acc_clr(acc_clr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p),
        .rsp_carryout(rsp_carryout), .busy(busy),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c),
        .dsp_carryin(dsp_carryin), .dsp_opmode(dsp_opmode),
        .dsp_ce(dsp_ce), .dsp_cep(dsp_cep), .dsp_rstp(dsp_rstp),
        .dsp_p(dsp_p), .dsp_carryout(dsp_carryout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slice model: stage-0 regs, pre-adder/B1+A1, M, P. No reset except RSTP.
    logic [17:0] s_a0, s_b0, s_d, s_a1, s_b1;
    logic [47:0] s_c;
    logic [7:0]  s_op;
    logic        s_cin;
    logic [35:0] s_m;
    logic [47:0] x_mux, z_mux;
    logic [48:0] post;

    always_comb begin
        x_mux = (s_op[1:0] == 2'd1) ? {12'd0, s_m} : 48'd0;
        case (s_op[3:2])
            2'd2:    z_mux = dsp_p;
            2'd3:    z_mux = s_c;
            default: z_mux = 48'd0;
        endcase
        if (s_op[7]) post = {1'b0, z_mux} - ({1'b0, x_mux} + {48'd0, s_cin});
        else         post = {1'b0, z_mux} + {1'b0, x_mux} + {48'd0, s_cin};
    end

    always @(posedge clk) begin
        if (dsp_ce) begin
            s_a0  <= dsp_a;
            s_b0  <= dsp_b;
            s_d   <= dsp_d;
            s_c   <= dsp_c;
            s_op  <= dsp_opmode;
            s_cin <= dsp_carryin;
            s_a1  <= s_a0;
            s_b1  <= s_op[4] ? (s_op[6] ? s_d - s_b0 : s_d + s_b0) : s_b0;
            s_m   <= s_a1 * s_b1;
        end
        if (dsp_rstp) begin
            dsp_p        <= 48'd0;
            dsp_carryout <= 1'b0;
        end else if (dsp_cep) begin
            dsp_p        <= post[47:0];
            dsp_carryout <= post[48];
        end
    end

    int total = 0;
    int bad = 0;
    int cep_cnt = 0;
    int rstp_cnt = 0;

    typedef struct packed {
        logic [47:0] p;
        logic        co;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: compares on every completed response handshake.
    always @(negedge clk) begin
        exp_t e;
        cep_cnt  += int'(dsp_cep);
        rstp_cnt += int'(dsp_rstp);
        if (rsp_valid && rsp_ready && !rst) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got p=%0h with no expected entry", rsp_p);
            end else begin
                e = exp_q.pop_front();
                check("rsp_p", 128'(rsp_p), 128'(e.p));
                check("rsp_carryout", 128'(rsp_carryout), 128'(e.co));
            end
        end
    end

    task automatic drive_req(input logic [1:0] op, input logic [17:0] a, input logic [17:0] b,
                             input logic [17:0] d, input logic [47:0] c, input logic cin);
        req_op = op; req_a = a; req_b = b; req_d = d; req_c = c; req_carryin = cin;
        req_valid = 1'b1;
    endtask

    task automatic start_req(input logic [1:0] op, input logic [17:0] a, input logic [17:0] b,
                             input logic [17:0] d, input logic [47:0] c, input logic cin,
                             input logic [47:0] ep, input logic eco);
        exp_t e;
        e.p = ep;
        e.co = eco;
        exp_q.push_back(e);
        drive_req(op, a, b, d, c, cin);
    endtask

    // Waits for acceptance, checks latency and single CEP, optional backpressure, then idle.
    task automatic finish_req(input int hold, output int waits);
        int lat;
        int c0;
        waits = 0;
        @(negedge clk);
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: req_ready=%0b expected 1", req_ready);
        end
        c0 = cep_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 128'(lat), 128'(LAT));
        if (hold > 0) begin
            req_valid = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                check("bp_rsp_valid", 128'(rsp_valid), 128'd1);
                check("bp_rsp_p", 128'(rsp_p), 128'(exp_q[0].p));
                check("bp_req_ready", 128'(req_ready), 128'd0);
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("cep_once", 128'(cep_cnt - c0), 128'd1);
        check("busy_after", 128'(busy), 128'd0);
        check("rsp_valid_after", 128'(rsp_valid), 128'd0);
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({dsp_a, dsp_b, dsp_d, dsp_c, dsp_carryin, dsp_opmode, dsp_ce, dsp_cep,
                     dsp_rstp, rsp_valid, rsp_p, rsp_carryout, busy, req_ready});
    endfunction

    initial begin
        int w;
        int r0;
        rst = 1'b1;
        req_valid = 1'b0; req_op = 2'd0; req_a = '0; req_b = '0; req_d = '0; req_c = '0;
        req_carryin = 1'b0; acc_clr = 1'b0; rsp_ready = 1'b1;
        #1;
        check("reset_outs", all_outs(), 128'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("ready_after_rst", 128'(req_ready), 128'd1);
        check("busy_idle", 128'(busy), 128'd0);
        @(posedge clk); #1;

        start_req(2'd0, 18'd10, 18'd20, 18'd30, 48'd50, 1'b1, 48'd551, 1'b0);
        finish_req(0, w);
        check("opmode_op0", 128'(dsp_opmode), 128'(8'b0011_1101));
        check("operands_retained", 128'(dsp_d), 128'd30);

        start_req(2'd1, 18'd10, 18'd20, 18'd0, 48'd600, 1'b1, 48'd399, 1'b0);
        finish_req(0, w);
        start_req(2'd1, 18'd1, 18'd1, 18'd0, 48'd0, 1'b0, 48'hFFFF_FFFF_FFFF, 1'b1);
        finish_req(0, w);
        check("opmode_op1", 128'(dsp_opmode), 128'(8'b1000_1101));

        r0 = rstp_cnt;
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        check("clr_rstp", 128'(dsp_rstp), 128'd1);
        check("clr_ready", 128'(req_ready), 128'd0);
        @(posedge clk); #1;
        check("rstp_one_cycle", 128'(rstp_cnt - r0), 128'd1);
        start_req(2'd3, 18'd3, 18'd4, 18'd0, 48'd0, 1'b0, 48'd12, 1'b0);
        finish_req(0, w);
        start_req(2'd3, 18'd3, 18'd4, 18'd0, 48'd0, 1'b0, 48'd24, 1'b0);
        finish_req(0, w);

        rsp_ready = 1'b0;
        start_req(2'd2, 18'd5, 18'd9, 18'd0, 48'd0, 1'b0, 48'd45, 1'b0);
        finish_req(5, w);

        start_req(2'd2, 18'd7, 18'd6, 18'd0, 48'd0, 1'b0, 48'd42, 1'b0);
        acc_clr = 1'b1;
        @(negedge clk);
        check("clr_priority_ready", 128'(req_ready), 128'd0);
        @(posedge clk); #1;
        check("clr_priority_rstp", 128'(dsp_rstp), 128'd1);
        acc_clr = 1'b0;
        finish_req(0, w);
        check("accept_after_clr", 128'(w), 128'd1);

        drive_req(2'd0, 18'd10, 18'd20, 18'd30, 48'd50, 1'b1);
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("run_ce_before_rst", 128'(dsp_ce), 128'd1);
        rst = 1'b1;
        #1;
        check("midrun_rst_outs", all_outs(), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("ready_after_midrun_rst", 128'(req_ready), 128'd1);
        start_req(2'd0, 18'd10, 18'd20, 18'd30, 48'd50, 1'b1, 48'd551, 1'b0);
        finish_req(0, w);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dsp48a1_op_sequencer.md
Name: dsp48a1_op_sequencer

Overview:
Operation sequencer on the driving side of the DSP48A1 slice. It accepts one arithmetic request at a time over a valid/ready handshake and drives the slice's A/B/D/C/CARRYIN/OPMODE inputs and its clock enables. It waits out the slice's fully-registered pipeline and returns P/CARRYOUT over a valid/ready response handshake. It also owns P-register clearing for accumulate chains.

Parameters:
LATENCY, 4, slice clock edges from operand presentation to P capture with all stage registers enabled (A0/B0/D/C/OPMODE, B1/A1, M, P); legal range 2..15.

Ports:
clk  input  1  rising-edge clock, shared with DSP48A1
rst  input  1  asynchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_op  input  2  0: (D+B)*A+C+cin; 1: C-(B*A+cin); 2: B*A (P load); 3: P+(D+B)*A (accumulate)
req_a, req_b, req_d  input  18  operands
req_c  input  48  C operand
req_carryin  input  1  carry-in
acc_clr  input  1  request one-cycle P-register clear
rsp_valid  output  1  result present
rsp_ready  input  1  consumer takes result
rsp_p  output  48  result
rsp_carryout  output  1  slice CARRYOUT for the result
busy  output  1  high in any state other than IDLE
dsp_a, dsp_b, dsp_d  output  18  to slice A/B/D
dsp_c  output  48  to slice C
dsp_carryin  output  1  to slice CARRYIN
dsp_opmode  output  8  to slice OPMODE
dsp_ce  output  1  to CEA/CEB/CEC/CED/CEM/CECARRYIN/CEOPMODE
dsp_cep  output  1  to CEP
dsp_rstp  output  1  to RSTP
dsp_p  input  48  from slice P
dsp_carryout  input  1  from slice CARRYOUT

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All dsp_* outputs, rsp_valid, busy and the cycle counter go to 0.
  - req_ready goes to 1 once rst is released.
- OPMODE encoding is [7] post-sub, [6] pre-sub, [5] carry-in select, [4] pre-adder use, [3:2] Z mux, [1:0] X mux. dsp_opmode by op:
  - op0 = 8'b00011101
  - op1 = 8'b10001101
  - op2 = 8'b00000001
  - op3 = 8'b00011001
  - Bit 5 is always replaced by req_carryin. dsp_carryin is also driven with req_carryin.
- State IDLE:
  - req_ready = 1 unless acc_clr = 1.
  - If acc_clr = 1, go to CLR. acc_clr has priority, and a coincident request is not accepted.
  - Otherwise, on req_valid && req_ready, register the operands into dsp_a/b/d/c, dsp_carryin and dsp_opmode, clear the counter and go to RUN.
- State CLR (one cycle):
  - dsp_rstp = 1, req_ready = 0, then return to IDLE.
  - acc_clr outside IDLE is ignored.
- State RUN:
  - dsp_ce = 1 and dsp_* operands held stable.
  - Counter increments 0..LATENCY-1.
  - dsp_cep = 1 only while counter == LATENCY-1, so the P register captures exactly once per operation. This is required for correct op3 accumulation.
  - After the counter==LATENCY-1 edge, dsp_ce = 0 and the state goes to RESP.
- State RESP:
  - rsp_valid = 1; rsp_p = dsp_p and rsp_carryout = dsp_carryout (stable, since CEP = 0).
  - Hold until rsp_ready = 1; on that edge go to IDLE.
  - A new request is not accepted in the same cycle.
- Latency: rsp_valid rises exactly LATENCY cycles after the request-accept edge. Throughput is one operation per LATENCY+2 cycles minimum.
- Operand registers retain their last values in IDLE; they are not zeroed after an operation.
- Arithmetic is the slice's: 48-bit wrap-around. For subtraction, CARRYOUT = borrow as produced by the slice; it is passed through unmodified.
- Reset during RUN or RESP: the in-flight result is discarded, rsp_valid drops to 0 immediately, and dsp_ce/dsp_cep drop to 0.

Test Plan:
- Op0, A=10 B=20 D=30 C=50 cin=1 -> rsp_valid 4 cycles after accept; rsp_p=551, rsp_carryout=0; dsp_opmode=8'b00111101.
- Op1, A=10 B=20 C=600 cin=1 -> rsp_p=399, carryout=0. Then op1 with A=1 B=1 C=0 cin=0 -> rsp_p=48'hFFFFFFFFFFFF, carryout=1.
- acc_clr, then op3 twice with A=3 B=4 D=0 -> dsp_rstp pulses one cycle; results 12 then 24. dsp_cep high exactly one cycle per op.
- Backpressure: rsp_ready held low 5 cycles in RESP -> rsp_valid stays 1, rsp_p constant, req_ready=0, a new req_valid is not accepted.
- acc_clr and req_valid asserted together in IDLE -> CLR taken, request accepted the cycle after CLR, then op2 A=7 B=6 -> rsp_p=42.
- rst asserted mid-RUN (counter=2) -> all outputs 0 asynchronously, busy=0. After release, req_ready=1 and the next op0 returns the correct result.
